// File: rtl/fmap_pkg.sv
// Shared definitions for the conv feature-map buffers.
package fmap_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_BYTES = 4;
  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam int NBANKS = 2;

  typedef logic bank_idx_t;

  typedef struct packed {
    logic      vld;
    bank_idx_t bank;
  } rd_tag_t;
endpackage

// File: rtl/fmap_bank_mem.sv
// One feature-map bank: byte-enabled word writes,
// registered multi-lane byte reads that wrap at the bank end.
module fmap_bank_mem
  import fmap_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int RD_LANES = 1,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WORD_BYTES-1:0]      we_i,
  input  logic [ADDR_W-1:0]          waddr_i,
  input  logic [WORD_W-1:0]          wdata_i,
  input  logic                       re_i,
  input  logic [ADDR_W-1:0]          raddr_i,
  output logic [RD_LANES*BYTE_W-1:0] rdata_o
);

  logic [BYTE_W-1:0]          mem_q [DEPTH];
  logic [RD_LANES*BYTE_W-1:0] rdata_q;
  logic [ADDR_W-1:0]          wbase;
  logic                       unused_waddr;

  assign wbase = {waddr_i[ADDR_W-1:2], 2'b00};
  assign unused_waddr = ^waddr_i[1:0];

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (we_i[k]) begin
        mem_q[wbase + ADDR_W'(k)] <=
          wdata_i[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Address add is ADDR_W wide, so lanes wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      for (int l = 0; l < RD_LANES; l++) begin
        rdata_q[l*BYTE_W +: BYTE_W] <=
          mem_q[raddr_i + ADDR_W'(l)];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fmap_pingpong_ram.sv
// Double-buffered feature-map RAM: loader fills one bank
// while the conv engine reads the other.
module fmap_pingpong_ram
  import fmap_pkg::BYTE_W;
  import fmap_pkg::bank_idx_t;
  import fmap_pkg::rd_tag_t;
#(
  parameter int DEPTH      = 1024,
  parameter int WORD_BYTES = 4,
  parameter int RD_LANES   = 1,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WORD_BYTES-1:0]      wr_en,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [31:0]                wdata,
  input  logic                       wr_done,
  output logic                       wr_ready,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          raddr,
  input  logic                       rd_done,
  output logic                       rd_avail,
  output logic                       rd_valid,
  output logic [8*RD_LANES-1:0]      rd_data
);

  logic [1:0]        full_q, full_d;
  bank_idx_t         wr_sel_q, wr_sel_d;
  bank_idx_t         rd_sel_q, rd_sel_d;
  rd_tag_t           s1_q, s1_d;
  rd_tag_t           s2_q, s2_d;
  logic [ADDR_W-1:0] s1_addr_q;
  logic              wr_fin, rd_go, rd_fin;

  logic [RD_LANES*BYTE_W-1:0] bank_rdata [2];

  assign wr_ready = !full_q[wr_sel_q];
  assign rd_avail = full_q[rd_sel_q];
  assign wr_fin   = wr_done && wr_ready;
  assign rd_go    = rd_en && rd_avail;
  assign rd_fin   = rd_done && rd_avail;

  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    s1_d.vld  = rd_go;
    s1_d.bank = rd_sel_q;
    s2_d.vld  = s1_q.vld;
    s2_d.bank = s2_q.bank;
    // Bank tag only moves with real data, so rd_data holds.
    if (s1_q.vld) begin
      s2_d.bank = s1_q.bank;
    end
    if (wr_fin) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    if (rd_fin) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_go) begin
      s1_addr_q <= raddr;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [WORD_BYTES-1:0] we;
    logic                  re;

    assign we = (wr_ready && wr_sel_q == bank_idx_t'(b))
              ? wr_en : '0;
    assign re = s1_q.vld && s1_q.bank == bank_idx_t'(b);

    fmap_bank_mem #(
      .DEPTH    (DEPTH),
      .RD_LANES (RD_LANES),
      .ADDR_W   (ADDR_W)
    ) u_mem (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .re_i    (re),
      .raddr_i (s1_addr_q),
      .rdata_o (bank_rdata[b])
    );
  end

  assign rd_valid = s2_q.vld;
  assign rd_data  = bank_rdata[s2_q.bank];

endmodule
